ps2_keycode: RTL and testbench
==============================

# ps2_keycode

Receives a PS/2 keyboard's serial clock/data pair, deframes scan-code set 2 bytes, and translates make/break sequences into the 8-bit USB HID usage `keycode` that the game-logic sprite modules (player movement, fire) consume. It sits between the board PS/2 connector and every module that takes `keycode`. It replaces the software keyboard path with a pure-RTL source. `keycode` holds the most recently pressed mapped key until that key is released.

## Interface
- `TIMEOUT_CYCLES`, 50000: Clk cycles without a PS/2 falling edge before a partial frame is abandoned (1 ms at 50 MHz).
- `FILTER_LEN`, 4: consecutive identical synchronized samples required to accept a PS2_CLK level change.

- `Clk`  in  1  system clock, 50 MHz.
- `Reset`  in  1  reset `Reset`, synchronous, active-high; clock `Clk`.
- `PS2_CLK`  in  1  keyboard clock, asynchronous, idle high.
- `PS2_DAT`  in  1  keyboard data, asynchronous, idle high.
- `keycode`  out  8  HID usage of the held key; 0 when none.
- `key_event`  out  1  one-cycle pulse when `keycode` changes.
- `frame_err`  out  1  one-cycle pulse on a bad start/stop/parity bit or a timeout.

## Operation
- Input conditioning: 2-FF synchronizer on both lines. PS2_CLK passes through a FILTER_LEN-sample glitch filter. A filtered 1→0 transition produces `fall`, and PS2_DAT is sampled on `fall`.
- Receiver FSM: IDLE → DATA → PARITY → STOP → IDLE.
  - IDLE: on `fall`, if DAT=0 go to DATA; else pulse `frame_err` and stay.
  - DATA: shift in 8 bits LSB-first using a 3-bit counter. After bit 7, go to PARITY.
  - PARITY: latch the bit.
  - STOP: if DAT=1 (and parity OK), emit `byte_valid` with the byte. Otherwise pulse `frame_err` and emit nothing. Return to IDLE.
  - Watchdog: a counter resets on every `fall`. If it reaches TIMEOUT_CYCLES in any non-IDLE state, go to IDLE and pulse `frame_err`.
- Decoder (acts on `byte_valid`):
  - 0xE0 sets `ext`.
  - 0xF0 sets `brk`.
  - Any other byte is looked up with `ext`, then both flags clear.
- Mapping (ext, code → HID):
  - E0 6B → 80 (left); E0 74 → 79 (right); E0 75 → 82 (up); E0 72 → 81 (down).
  - 29 → 44 (space); 1C → 4 (A); 23 → 7 (D); 1D → 26 (W); 1B → 22 (S); 5A → 40 (enter).
  - All others are unmapped.
- Make of a mapped key: `keycode` ← HID.
- Break: if HID equals the current `keycode`, then `keycode` ← 0. Otherwise no change.
- Unmapped make/break: no change. Typematic repeats of the same make: no change and no `key_event`.
- `frame_err` clears `ext` and `brk`.

## Timing
- Reset values:
  - Outputs: `keycode`=0, `key_event`=0, `frame_err`=0.
  - Internal: FSM=IDLE, `ext`=`brk`=0, watchdog=0, filter/sync registers=1.
- Edge latency: 2 sync cycles + FILTER_LEN filter cycles from a pad edge to `fall`.
- `byte_valid` is asserted in the cycle after the `fall` that samples the stop bit.
- `keycode` and `key_event` update in the cycle after `byte_valid`. `key_event` lasts exactly 1 cycle.
- `frame_err` is registered and lasts 1 cycle.
- `Reset` mid-frame discards the partial byte and any pending prefix flags.
- A `fall` in the same cycle the watchdog expires counts as the timeout: go to IDLE, pulse `frame_err`, and ignore that edge.

## Configuration
- `PS2_PARITY_CHECK_EN` defined: the STOP state also requires odd parity over data+parity. A mismatch pulses `frame_err` and drops the byte.
- Undefined: the parity bit is sampled and ignored. Only start/stop/timeout errors are reported.

## Structure
- Package `ps2_pkg`:
  - `rx_state_t` enum (IDLE, DATA, PARITY, STOP).
  - Constants `PS2_EXT`=8'hE0 and `PS2_BRK`=8'hF0.
  - HID constants `HID_LEFT`=80, `HID_RIGHT`=79, `HID_UP`=82, `HID_DOWN`=81, `HID_SPACE`=44, and the rest of the map.
  - Function `scan_to_hid(ext, code)` returning `{valid, hid[7:0]}`.
- Sub-module `ps2_rx`: synchronizer, filter, FSM, and watchdog, producing `byte_valid`, `byte_data`, and `frame_err`. The top level holds the decoder and the `keycode` register.

## Test plan
- E0 6B, then E0 F0 6B, with correct framing → `keycode` = 80 with a `key_event` pulse, then 0 with a second pulse.
- Make 1C (A), make E0 74 (right), break 1C → `keycode` = 4, then 79, and stays 79 after the break of A.
- Make 29 sent 3 times (typematic) → `keycode` = 44 with exactly one `key_event` pulse.
- Byte 0x1C with a wrong parity bit → with `PS2_PARITY_CHECK_EN`: `frame_err` pulse, `keycode` stays 0. Without the macro: `keycode` = 4.
- 4 bits of a frame, then idle for TIMEOUT_CYCLES+10 → one `frame_err` pulse, FSM returns to IDLE, and a following clean 0x29 gives `keycode` = 44.
- 1-cycle PS2_CLK glitch low with FILTER_LEN=4 → no `fall`, no bit shifted. Also: `Reset` after the E0 prefix, then 6B → `keycode` = 0, since 6B without the prefix is unmapped.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 scan-code set 2 types, prefix bytes and the scan-to-HID lookup.
// Pure combinational helpers; no latency, no backpressure.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  localparam logic [7:0] HID_LEFT  = 8'd80;
  localparam logic [7:0] HID_RIGHT = 8'd79;
  localparam logic [7:0] HID_UP    = 8'd82;
  localparam logic [7:0] HID_DOWN  = 8'd81;
  localparam logic [7:0] HID_SPACE = 8'd44;
  localparam logic [7:0] HID_A     = 8'd4;
  localparam logic [7:0] HID_D     = 8'd7;
  localparam logic [7:0] HID_W     = 8'd26;
  localparam logic [7:0] HID_S     = 8'd22;
  localparam logic [7:0] HID_ENTER = 8'd40;

  // Returns {valid, hid}; valid=0 for any key the game logic does not use.
  function automatic logic [8:0] scan_to_hid(input logic ext, input logic [7:0] code);
    logic [8:0] r;
    r = 9'd0;
    if (ext) begin
      case (code)
        8'h6B:   r = {1'b1, HID_LEFT};
        8'h74:   r = {1'b1, HID_RIGHT};
        8'h75:   r = {1'b1, HID_UP};
        8'h72:   r = {1'b1, HID_DOWN};
        default: r = 9'd0;
      endcase
    end else begin
      case (code)
        8'h29:   r = {1'b1, HID_SPACE};
        8'h1C:   r = {1'b1, HID_A};
        8'h23:   r = {1'b1, HID_D};
        8'h1D:   r = {1'b1, HID_W};
        8'h1B:   r = {1'b1, HID_S};
        8'h5A:   r = {1'b1, HID_ENTER};
        default: r = 9'd0;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: sync + glitch filter + deframing FSM + watchdog; byte_valid one cycle after the stop-bit fall.
// No backpressure (keyboard cannot be stalled); PS2_PARITY_CHECK_EN enables odd-parity rejection.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FILTER_LEN     = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 2);

  logic                  clk_s1, clk_s2, dat_s1, dat_s2;
  logic [FILTER_LEN-1:0] clk_sh;
  logic                  clk_f;
  logic                  fall;
  logic                  expire;
  logic                  frame_ok;
  rx_state_t             state;
  logic [2:0]            bit_cnt;
  logic [7:0]            shreg;
  logic [WD_W-1:0]       wdog;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
      clk_sh <= '1;
      clk_f  <= 1'b1;
    end else begin
      clk_s1 <= PS2_CLK;
      clk_s2 <= clk_s1;
      dat_s1 <= PS2_DAT;
      dat_s2 <= dat_s1;
      clk_sh <= {clk_sh[FILTER_LEN-2:0], clk_s2};
      if (clk_sh == '0)
        clk_f <= 1'b0;
      else if (clk_sh == '1)
        clk_f <= 1'b1;
    end
  end

  // Falls in the cycle the filter first sees FILTER_LEN lows, before clk_f drops.
  assign fall   = clk_f && (clk_sh == '0);
  assign expire = (state != IDLE) && (wdog >= WD_W'(TIMEOUT_CYCLES));

`ifdef PS2_PARITY_CHECK_EN
  logic par;
  assign frame_ok = dat_s2 && (^{shreg, par});
`else
  assign frame_ok = dat_s2;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      bit_cnt    <= 3'd0;
      shreg      <= 8'd0;
      wdog       <= '0;
      byte_valid <= 1'b0;
      byte_data  <= 8'd0;
      frame_err  <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par        <= 1'b0;
`endif
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (state == IDLE || fall || expire)
        wdog <= '0;
      else
        wdog <= wdog + WD_W'(1);

      // Timeout wins over a coincident edge; that edge is dropped.
      if (expire) begin
        state     <= IDLE;
        frame_err <= 1'b1;
      end else if (fall) begin
        case (state)
          IDLE: begin
            if (!dat_s2) begin
              state   <= DATA;
              bit_cnt <= 3'd0;
            end else begin
              frame_err <= 1'b1;
            end
          end
          DATA: begin
            shreg   <= {dat_s2, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7)
              state <= PARITY;
          end
          PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
            par <= dat_s2;
`endif
            state <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (frame_ok) begin
              byte_valid <= 1'b1;
              byte_data  <= shreg;
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/ps2_keycode.sv
// PS/2 keyboard to HID keycode: holds the last pressed mapped key until its break; updates 1 cycle after byte_valid.
// No backpressure; parity checking in the receiver is enabled by PS2_PARITY_CHECK_EN.
module ps2_keycode
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FILTER_LEN     = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] keycode,
  output logic       key_event,
  output logic       frame_err
);

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       ext, brk;
  logic [8:0] lut;

  ps2_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .FILTER_LEN    (FILTER_LEN)
  ) u_rx (
    .Clk       (Clk),
    .Reset     (Reset),
    .PS2_CLK   (PS2_CLK),
    .PS2_DAT   (PS2_DAT),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err)
  );

  assign lut = scan_to_hid(ext, byte_data);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      keycode   <= 8'd0;
      key_event <= 1'b0;
      ext       <= 1'b0;
      brk       <= 1'b0;
    end else begin
      key_event <= 1'b0;
      if (frame_err) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end else if (byte_valid) begin
        if (byte_data == PS2_EXT) begin
          ext <= 1'b1;
        end else if (byte_data == PS2_BRK) begin
          brk <= 1'b1;
        end else begin
          ext <= 1'b0;
          brk <= 1'b0;
          // Releasing a key other than the held one leaves the held key in place.
          if (lut[8]) begin
            if (brk) begin
              if (lut[7:0] == keycode) begin
                keycode   <= 8'd0;
                key_event <= 1'b1;
              end
            end else if (lut[7:0] != keycode) begin
              keycode   <= lut[7:0];
              key_event <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_keycode.sv
// Directed bench for ps2_keycode: bit-banged PS/2 frames, byte-level keyboard model and per-cycle compare.
module tb_ps2_keycode;

  localparam int TO   = 1000;
  localparam int HALF = 20;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       PS2_CLK = 1'b1;
  logic       PS2_DAT = 1'b1;
  logic [7:0] keycode;
  logic       key_event;
  logic       frame_err;

  int tests = 0;
  int fails = 0;
  int ev_seen = 0;

  // Model state
  bit         m_ext, m_brk;
  logic [7:0] m_key;
  logic [7:0] ev_q[$];
  int         err_pend = 0;
  int         hid_map[int];
  logic [7:0] prev_key = 8'd0;

  ps2_keycode #(.TIMEOUT_CYCLES(TO), .FILTER_LEN(4)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .PS2_CLK  (PS2_CLK),
    .PS2_DAT  (PS2_DAT),
    .keycode  (keycode),
    .key_event(key_event),
    .frame_err(frame_err)
  );

  always #10 Clk = ~Clk;

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // Keyboard semantics: one call per received frame, in transmit order.
  task automatic model_frame(input logic [7:0] b, input bit ok);
    int k;
    if (!ok) begin
      m_ext = 0;
      m_brk = 0;
      err_pend++;
      return;
    end
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      k = (m_ext ? 256 : 0) + int'(b);
      if (hid_map.exists(k)) begin
        if (m_brk) begin
          if (hid_map[k] == int'(m_key)) begin
            m_key = 8'd0;
            ev_q.push_back(8'd0);
          end
        end else if (hid_map[k] != int'(m_key)) begin
          m_key = 8'(hid_map[k]);
          ev_q.push_back(m_key);
        end
      end
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input bit glitch);
    logic [10:0] bits;
    logic        par;
    par = ~^b;
    if (bad_par) par = ~par;
    bits = {~bad_stop, par, b, 1'b0};
`ifdef PS2_PARITY_CHECK_EN
    model_frame(b, !bad_stop && !bad_par);
`else
    model_frame(b, !bad_stop);
`endif
    for (int i = 0; i < 11; i++) begin
      PS2_DAT = bits[i];
      wait_cyc(HALF);
      if (glitch && i == 4) begin
        PS2_CLK = 1'b0;
        wait_cyc(1);
        PS2_CLK = 1'b1;
        wait_cyc(HALF);
      end
      PS2_CLK = 1'b0;
      wait_cyc(HALF);
      PS2_CLK = 1'b1;
    end
    PS2_DAT = 1'b1;
    wait_cyc(3 * HALF);
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_key(input string name, input logic [7:0] exp);
    tests++;
    if (keycode !== exp) begin
      fails++;
      $display("FAIL %s: keycode=%0d required=%0d", name, keycode, exp);
    end
  endtask

  task automatic check_drained(input string name);
    tests++;
    if (ev_q.size() != 0 || err_pend != 0) begin
      fails++;
      $display("FAIL %s: missing key_event=%0d missing frame_err=%0d required 0 and 0",
               name, ev_q.size(), err_pend);
    end
  endtask

  // Per-cycle compare against the model's expected event stream.
  always @(negedge Clk) begin
    logic [7:0] exp;
    if (!Reset) begin
      if (key_event) begin
        tests++;
        ev_seen++;
        if (ev_q.size() == 0) begin
          fails++;
          $display("FAIL key_event_unexpected: keycode=%0d required no event", keycode);
        end else begin
          exp = ev_q.pop_front();
          if (keycode !== exp) begin
            fails++;
            $display("FAIL key_event_value: keycode=%0d required=%0d", keycode, exp);
          end
        end
      end else if (keycode !== prev_key) begin
        tests++;
        fails++;
        $display("FAIL keycode_silent_change: keycode=%0d required=%0d", keycode, prev_key);
      end
      if (frame_err) begin
        tests++;
        if (err_pend == 0) begin
          fails++;
          $display("FAIL frame_err_unexpected: frame_err=1 required 0");
        end else begin
          err_pend--;
        end
      end
    end
    prev_key = keycode;
  end

  initial begin
    int ev0;
    hid_map[256 + 'h6B] = 80;
    hid_map[256 + 'h74] = 79;
    hid_map[256 + 'h75] = 82;
    hid_map[256 + 'h72] = 81;
    hid_map['h29] = 44;
    hid_map['h1C] = 4;
    hid_map['h23] = 7;
    hid_map['h1D] = 26;
    hid_map['h1B] = 22;
    hid_map['h5A] = 40;
    m_ext = 0;
    m_brk = 0;
    m_key = 8'd0;

    wait_cyc(5);
    tests++;
    if (keycode !== 8'd0 || key_event !== 1'b0 || frame_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_values: keycode=%0d key_event=%0b frame_err=%0b required 0 0 0",
               keycode, key_event, frame_err);
    end
    Reset = 1'b0;
    wait_cyc(10);

    // Extended make and break of LEFT
    send(8'hE0); send(8'h6B);
    check_key("left_make", 8'd80);
    send(8'hE0); send(8'hF0); send(8'h6B);
    check_key("left_break", 8'd0);
    check_drained("left_events");

    // A, then RIGHT, then release of A leaves RIGHT held
    send(8'h1C);
    check_key("a_make", 8'd4);
    send(8'hE0); send(8'h74);
    check_key("right_make", 8'd79);
    send(8'hF0); send(8'h1C);
    check_key("a_break_other_held", 8'd79);
    send(8'hE0); send(8'hF0); send(8'h74);
    check_key("right_break", 8'd0);
    check_drained("ab_events");

    // Typematic repeats of space
    ev0 = ev_seen;
    send(8'h29); send(8'h29); send(8'h29);
    check_key("space_typematic", 8'd44);
    tests++;
    if (ev_seen - ev0 != 1) begin
      fails++;
      $display("FAIL typematic_event_count: events=%0d required=1", ev_seen - ev0);
    end
    send(8'hF0); send(8'h29);
    check_key("space_break", 8'd0);
    check_drained("typematic_events");

    // Wrong parity on 0x1C
    send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
`ifdef PS2_PARITY_CHECK_EN
    check_key("bad_parity", 8'd0);
`else
    check_key("bad_parity", 8'd4);
`endif
    send(8'hF0); send(8'h1C);
    check_key("bad_parity_cleanup", 8'd0);
    check_drained("parity_events");

    // Bad stop bit after a break prefix: error, and the prefix is dropped
    send(8'hD0);
    send(8'h1D);
    check_key("w_make", 8'd26);
    send(8'hF0);
    send_frame(8'h23, 1'b0, 1'b1, 1'b0);
    send(8'h1D);
    check_key("bad_stop_clears_brk", 8'd26);
    send(8'hF0); send(8'h1D);
    check_key("w_break", 8'd0);
    check_drained("stop_events");

    // Timeout after a partial frame, with a pending E0 prefix
    send(8'hE0);
    model_frame(8'h00, 1'b0);
    PS2_DAT = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_cyc(HALF);
      PS2_CLK = 1'b0;
      wait_cyc(HALF);
      PS2_CLK = 1'b1;
      PS2_DAT = 1'b1;
    end
    wait_cyc(TO + 10 + 50);
    check_drained("timeout_err");
    send(8'h29);
    check_key("after_timeout_space", 8'd44);
    send(8'hF0); send(8'h29);
    check_drained("timeout_events");

    // Glitches: idle glitch and mid-frame glitch must both be ignored
    PS2_CLK = 1'b0;
    wait_cyc(1);
    PS2_CLK = 1'b1;
    wait_cyc(40);
    check_drained("idle_glitch");
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
    check_key("glitch_enter", 8'd40);
    send(8'hF0); send(8'h5A);
    check_drained("glitch_events");

    // Reset after E0 drops the prefix; bare 6B is unmapped
    send(8'hE0);
    Reset = 1'b1;
    wait_cyc(3);
    Reset = 1'b0;
    m_ext = 0;
    m_brk = 0;
    m_key = 8'd0;
    wait_cyc(5);
    send(8'h6B);
    check_key("reset_drops_prefix", 8'd0);
    check_drained("reset_events");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
